uop_issue_queue: RTL
====================

UOP_ISSUE_QUEUE -- requirements
Module: uop_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, queue entries; fixed at 8 for this revision.
REQ-002 SHALL have parameter UOP_W, default 20, micro-op width.
REQ-003 SHALL have port clk  input  1  single clock; all state on posedge.
REQ-004 SHALL have port a_rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port uop_0, uop_1, uop_2  input  20 each  decoded micro-op bundle, program order uop_0 first.
REQ-006 SHALL have port uop_count  input  2  valid micro-ops in the bundle (0..3).
REQ-007 SHALL have port feed_ack  input  1  decoder asserts bundle valid.
REQ-008 SHALL have port feed_req  output  1  queue can accept a full bundle.
REQ-009 SHALL have port dec_hold  output  1  stall decoder; equals inverse of feed_req.
REQ-010 SHALL have port flush  input  1  branch taken or PC invalidate; discard queued micro-ops.
REQ-011 SHALL have port ex_uop  output  20  head micro-op to execute.
REQ-012 SHALL have port ex_valid  output  1  ex_uop valid.
REQ-013 SHALL have port ex_ready  input  1  execute unit accepts ex_uop.
REQ-014 SHALL have port mem_done  input  1  outstanding memory access complete.
REQ-015 SHALL have port q_level  output  4  occupied entries (0..8).

Function
REQ-016 Micro-op fields: [19:16] ALU, [15] MASK, [14] LD, [13] WR, [12] FLAGS, [11:8] DEST, [7:6] ALU_MUX, [5:3] B, [2:0] A; the block reads only LD and WR.
REQ-017 feed_req SHALL be combinational: 1 when (DEPTH - q_level) >= 3 and flush = 0.
REQ-018 A bundle SHALL be accepted on a cycle with feed_req = 1 and feed_ack = 1; uop_count entries are written from uop_0 upward into consecutive slots; uop_count = 0 writes nothing.
REQ-019 feed_ack while feed_req = 0 SHALL be ignored, with no write and no error.
REQ-020 Read/write pointers SHALL be 3-bit and wrap modulo 8; q_level SHALL never exceed 8 or underflow.
REQ-021 State machine SHALL have two states: ISSUE and WAIT_MEM.
REQ-022 In ISSUE: ex_valid = (q_level != 0); ex_uop = head entry when ex_valid, else 0.
REQ-023 In WAIT_MEM: ex_valid = 0 and ex_uop = 0.
REQ-024 Pop SHALL occur when ex_valid and ex_ready are both 1; head advances by one.
REQ-025 If the popped micro-op has LD or WR set, the next state SHALL be WAIT_MEM; otherwise the state stays ISSUE.
REQ-026 In WAIT_MEM, mem_done = 1 SHALL return to ISSUE next cycle; mem_done is ignored in ISSUE.
REQ-027 Simultaneous push and pop SHALL give q_level_next = q_level + uop_count - 1.
REQ-028 Throughput: 1 micro-op per cycle max; latency push to ex_valid is 1 cycle when the queue was empty.
REQ-029 flush SHALL reset pointers and q_level to 0 next cycle, and a bundle presented the same cycle SHALL be dropped.
REQ-030 On flush in ISSUE, a pop in that cycle SHALL still complete, and the flush clears the remainder.
REQ-031 WAIT_MEM SHALL NOT be aborted by flush; the outstanding memory operation completes via mem_done.

Reset
REQ-032 a_rst SHALL asynchronously clear pointers, q_level and all entries to 0, and set state to ISSUE.
REQ-033 During and after reset: ex_valid = 0, ex_uop = 0, q_level = 0, feed_req = 1 (when flush = 0), dec_hold = 0.
REQ-034 Reset mid-WAIT_MEM SHALL discard the wait; a later mem_done is ignored.

Structure
REQ-035 A shared package SHALL hold the micro-op field bit positions, UOP_W, DEPTH and the state enum {ISSUE, WAIT_MEM}.
REQ-036 Storage and pointers SHALL be one sub-module, uop_ring_buffer (3-write-port push, 1-read pop, clear); the FSM and handshake stay in uop_issue_queue.

Verification
REQ-037 Reset, then bundle of count 3 (ALU ops, LD = WR = 0), ex_ready = 1: q_level = 3, then ex_uop shows uop_0, uop_1, uop_2 on consecutive cycles, then q_level = 0.
REQ-038 Three count-3 bundles with ex_ready = 0: after two bundles q_level = 6, feed_req = 0 and dec_hold = 1; the third bundle is ignored and q_level stays 6.
REQ-039 Head micro-op with LD = 1 issued: ex_valid = 0 for N cycles until mem_done, then the next micro-op issues the cycle after mem_done.
REQ-040 q_level = 5 with flush and feed_ack (count 2) in the same cycle: next cycle q_level = 0, ex_valid = 0, and no micro-op from that bundle ever issues.
REQ-041 Push count 2 and pop in the same cycle at q_level = 4: q_level = 5; the pointer wrap past slot 7 preserves order.
REQ-042 a_rst asserted in WAIT_MEM: outputs reach their reset values immediately, state is ISSUE, and a subsequent mem_done pulse has no effect.

Source files
------------

// File: rtl/uop_issue_queue_pkg.sv
// Shared definitions for the micro-op issue queue: geometry, micro-op field
// positions and the issue state machine encoding.
package uop_issue_queue_pkg;

  localparam int UOP_W = 20;
  localparam int DEPTH = 8;
  localparam int PTR_W = 3;
  localparam int LVL_W = 4;

  localparam int ALU_HI    = 19;
  localparam int ALU_LO    = 16;
  localparam int MASK_BIT  = 15;
  localparam int LD_BIT    = 14;
  localparam int WR_BIT    = 13;
  localparam int FLAGS_BIT = 12;
  localparam int DEST_HI   = 11;
  localparam int DEST_LO   = 8;
  localparam int MUX_HI    = 7;
  localparam int MUX_LO    = 6;
  localparam int B_HI      = 5;
  localparam int B_LO      = 3;
  localparam int A_HI      = 2;
  localparam int A_LO      = 0;

  typedef enum logic {
    ISSUE    = 1'b0,
    WAIT_MEM = 1'b1
  } state_t;

endpackage

// File: rtl/uop_ring_buffer.sv
// Eight-entry circular micro-op store: up to three in-order writes per cycle,
// one read from the head, and a synchronous clear of pointers and level.
module uop_ring_buffer
  import uop_issue_queue_pkg::*;
#(
  parameter int DEPTH = uop_issue_queue_pkg::DEPTH,
  parameter int UOP_W = uop_issue_queue_pkg::UOP_W
) (
  input  logic             clk,
  input  logic             a_rst,
  input  logic             clear,
  input  logic [1:0]       push_count,
  input  logic [UOP_W-1:0] wr_data_0,
  input  logic [UOP_W-1:0] wr_data_1,
  input  logic [UOP_W-1:0] wr_data_2,
  input  logic             pop,
  output logic [UOP_W-1:0] rd_data,
  output logic [LVL_W-1:0] level
);

  logic [UOP_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_idx_1;
  logic [PTR_W-1:0] wr_idx_2;

  // Slot indices wrap naturally in 3 bits, so a bundle may straddle slot 7.
  assign wr_idx_1 = wr_ptr + PTR_W'(1);
  assign wr_idx_2 = wr_ptr + PTR_W'(2);
  assign rd_data  = mem[rd_ptr];

  // NOTE: state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      // NOTE: entries are cleared on reset so a freshly reset queue never
      // exposes stale micro-ops; this costs a reset net per storage bit.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_count >= 2'd1) mem[wr_ptr]   <= wr_data_0;
      if (push_count >= 2'd2) mem[wr_idx_1] <= wr_data_1;
      if (push_count == 2'd3) mem[wr_idx_2] <= wr_data_2;
      wr_ptr <= wr_ptr + PTR_W'(push_count);
      rd_ptr <= rd_ptr + PTR_W'(pop);
      level  <= level + LVL_W'(push_count) - LVL_W'(pop);
    end
  end

endmodule

// File: rtl/uop_issue_queue.sv
// Decoder-to-execute micro-op queue: accepts bundles of up to three micro-ops,
// issues one per cycle, and stalls issue while a memory micro-op is outstanding.
module uop_issue_queue
  import uop_issue_queue_pkg::*;
#(
  parameter int DEPTH = uop_issue_queue_pkg::DEPTH,
  parameter int UOP_W = uop_issue_queue_pkg::UOP_W
) (
  input  logic             clk,
  input  logic             a_rst,
  input  logic [UOP_W-1:0] uop_0,
  input  logic [UOP_W-1:0] uop_1,
  input  logic [UOP_W-1:0] uop_2,
  input  logic [1:0]       uop_count,
  input  logic             feed_ack,
  output logic             feed_req,
  output logic             dec_hold,
  input  logic             flush,
  output logic [UOP_W-1:0] ex_uop,
  output logic             ex_valid,
  input  logic             ex_ready,
  input  logic             mem_done,
  output logic [3:0]       q_level
);

  state_t           state;
  state_t           state_nxt;
  logic [UOP_W-1:0] head;
  logic             pop;
  logic [1:0]       push_count;

  // A bundle is only taken when a full three-entry bundle is guaranteed to fit.
  assign feed_req   = (q_level <= LVL_W'(DEPTH - 3)) && !flush;
  assign dec_hold   = ~feed_req;
  assign push_count = (feed_req && feed_ack) ? uop_count : 2'd0;
  assign pop        = ex_valid && ex_ready;

  uop_ring_buffer #(.DEPTH(DEPTH), .UOP_W(UOP_W)) u_ring (
    .clk        (clk),
    .a_rst      (a_rst),
    .clear      (flush),
    .push_count (push_count),
    .wr_data_0  (uop_0),
    .wr_data_1  (uop_1),
    .wr_data_2  (uop_2),
    .pop        (pop),
    .rd_data    (head),
    .level      (q_level)
  );

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) state <= ISSUE;
    else       state <= state_nxt;
  end

  // Flush does not touch the state: an outstanding memory access must still
  // be retired by mem_done.
  always_comb begin
    // NOTE: defaulting every always_comb output first prevents latch inference.
    state_nxt = state;
    unique case (state)
      ISSUE:    if (pop && (head[LD_BIT] || head[WR_BIT])) state_nxt = WAIT_MEM;
      WAIT_MEM: if (mem_done) state_nxt = ISSUE;
      default:  state_nxt = ISSUE;
    endcase
  end

  always_comb begin
    ex_valid = 1'b0;
    ex_uop   = '0;
    if (state == ISSUE && q_level != '0) begin
      ex_valid = 1'b1;
      ex_uop   = head;
    end
  end

endmodule
